// File: rtl/id_stage_vec_pipe.sv
// Decode stage of the SIMD AES core with scalar/vector register files and ID/EX register.
// Optional ID_FWD_EN adds a MEM-stage forwarding path into the operand read.
module id_stage_vec_pipe #(
    parameter  int INSTR_W = 21,
    parameter  int PC_W    = 12,
    parameter  int DATA_W  = 32,
    parameter  int LANES   = 4,
    parameter  int SREG_N  = 16,
    parameter  int VREG_N  = 16,
    localparam int VEC_W   = LANES * DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               flush,
    input  logic               wb_en,
    input  logic               vwb_en,
    input  logic [3:0]         wb_addr,
    input  logic [VEC_W-1:0]   wb_data,
    input  logic               ex_is_load,
    input  logic [4:0]         ex_rd,
`ifdef ID_FWD_EN
    input  logic               mem_fwd_en,
    input  logic [4:0]         mem_fwd_addr,
    input  logic [VEC_W-1:0]   mem_fwd_data,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VEC_W-1:0]   out_data1,
    output logic [VEC_W-1:0]   out_data2,
    output logic [DATA_W-1:0]  out_imm,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [4:0]         out_opcode,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_baddr,
    output logic               out_equal
);

    localparam logic [4:0] OP_JR  = 5'b11000;
    localparam logic [4:0] OP_JMP = 5'b11001;

    logic [DATA_W-1:0] sreg_q [SREG_N];
    logic [DATA_W-1:0] sreg_d [SREG_N];
    logic [VEC_W-1:0]  vreg_q [VREG_N];
    logic [VEC_W-1:0]  vreg_d [VREG_N];

    logic [4:0] opcode, rd, rs1, rs2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] s1, s2;
    logic [VEC_W-1:0]  op1, op2;
    logic              hz, load;
    logic              unused_bits;

    logic              valid_q, valid_d;
    logic [VEC_W-1:0]  data1_q, data1_d, data2_q, data2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [4:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [4:0]        opcode_q, opcode_d;
    logic [PC_W-1:0]   pc_q, pc_d, baddr_q, baddr_d;
    logic              equal_q, equal_d;

    assign unused_bits = ^instr_in[INSTR_W-1:20];

    // Reads see this cycle's writeback (write-through); scalar r0 is hardwired zero.
    function automatic logic [DATA_W-1:0] sread(input logic [3:0] a);
        if (a == 4'd0)
            return '0;
        if (wb_en && wb_addr == a)
            return wb_data[DATA_W-1:0];
        return sreg_q[a];
    endfunction

    function automatic logic [VEC_W-1:0] vread(input logic [3:0] a);
        if (vwb_en && wb_addr == a)
            return wb_data;
        return vreg_q[a];
    endfunction

    always_comb begin
        opcode = instr_in[19:15];
        rd     = instr_in[14:10];
        rs1    = (opcode == OP_JR) ? 5'd0 : instr_in[9:5];
        rs2    = instr_in[4:0];
        imm    = DATA_W'(instr_in[9:0]);
    end

    always_comb begin
        s1  = sread(rs1[3:0]);
        s2  = sread(rs2[3:0]);
        op1 = rs1[4] ? vread(rs1[3:0]) : VEC_W'(s1);
        op2 = rs2[4] ? vread(rs2[3:0]) : VEC_W'(s2);
`ifdef ID_FWD_EN
        if (mem_fwd_en && mem_fwd_addr == rs1 && rs1 != 5'd0) begin
            op1 = mem_fwd_data;
            s1  = mem_fwd_data[DATA_W-1:0];
        end
        if (mem_fwd_en && mem_fwd_addr == rs2 && rs2 != 5'd0) begin
            op2 = mem_fwd_data;
            s2  = mem_fwd_data[DATA_W-1:0];
        end
`endif
    end

    assign hz = ex_is_load && ex_rd != 5'd0 &&
                (ex_rd == rs1 || ex_rd == rs2);
    assign in_ready = !hz && (!valid_q || out_ready);
    assign load = in_valid && in_ready && !flush;

    always_comb begin
        sreg_d = sreg_q;
        vreg_d = vreg_q;
        if (wb_en && wb_addr != 4'd0)
            sreg_d[wb_addr] = wb_data[DATA_W-1:0];
        if (vwb_en)
            vreg_d[wb_addr] = wb_data;
    end

    always_comb begin
        valid_d  = valid_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        imm_d    = imm_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        opcode_d = opcode_q;
        pc_d     = pc_q;
        baddr_d  = baddr_q;
        equal_d  = equal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d  = 1'b1;
            data1_d  = op1;
            data2_d  = op2;
            imm_d    = imm;
            rd_d     = rd;
            rs1_d    = rs1;
            rs2_d    = rs2;
            opcode_d = opcode;
            pc_d     = pc_in;
            baddr_d  = imm[PC_W-1:0];
            equal_d  = (opcode == OP_JMP) || (s1 == s2);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SREG_N; i++)
                sreg_q[i] <= '0;
            for (int i = 0; i < VREG_N; i++)
                vreg_q[i] <= '0;
        end else begin
            sreg_q <= sreg_d;
            vreg_q <= vreg_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            data1_q  <= '0;
            data2_q  <= '0;
            imm_q    <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            opcode_q <= '0;
            pc_q     <= '0;
            baddr_q  <= '0;
            equal_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            imm_q    <= imm_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            opcode_q <= opcode_d;
            pc_q     <= pc_d;
            baddr_q  <= baddr_d;
            equal_q  <= equal_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data1  = data1_q;
    assign out_data2  = data2_q;
    assign out_imm    = imm_q;
    assign out_rd     = rd_q;
    assign out_rs1    = rs1_q;
    assign out_rs2    = rs2_q;
    assign out_opcode = opcode_q;
    assign out_pc     = pc_q;
    assign out_baddr  = baddr_q;
    assign out_equal  = equal_q;

endmodule
